// File: rtl/seq_tx_image_burst.sv
// Reads an image back from the R/G/B word SRAMs and hands each 4-pixel word
// to the TX message composer as one burst payload.
module seq_tx_image_burst #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_PIXELS = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       img_width,
  input  logic [15:0]       img_height,
  output logic              sram_r_rd_en,
  output logic              sram_g_rd_en,
  output logic              sram_b_rd_en,
  output logic [ADDR_W-1:0] sram_r_addr_rd,
  output logic [ADDR_W-1:0] sram_g_addr_rd,
  output logic [ADDR_W-1:0] sram_b_addr_rd,
  input  logic [31:0]       sram_r_rd_data,
  input  logic [31:0]       sram_g_rd_data,
  input  logic [31:0]       sram_b_rd_data,
  input  logic              cmpsr_busy,
  output logic              start_request_to_cmpsr,
  output logic [31:0]       red_burst,
  output logic [31:0]       green_burst,
  output logic [31:0]       blue_burst,
  output logic [2:0]        burst_valid_px,
  output logic              burst_last,
  output logic              tx_seq_burst_busy,
  output logic              tx_seq_burst_dn
);

  localparam int unsigned PX_W   = $clog2(MAX_PIXELS + 1);
  localparam int unsigned CMP_W  = (ADDR_W > PX_W) ? ADDR_W : PX_W;
  localparam int unsigned WAIT_W = 2;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, CAPTURE, SEND, WAIT_BUSY, WAIT_IDLE, DONE
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic [CMP_W-1:0]   last_addr;
  logic [1:0]         px_rem;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               rd_en;

  logic [31:0]        prod_c;
  logic [PX_W-1:0]    total_px_c;
  logic               is_last_c;
  logic [2:0]         vpx_c;
  logic [31:0]        red_c;
  logic [31:0]        green_c;
  logic [31:0]        blue_c;

  assign sram_r_rd_en   = rd_en;
  assign sram_g_rd_en   = rd_en;
  assign sram_b_rd_en   = rd_en;
  assign sram_r_addr_rd = addr;
  assign sram_g_addr_rd = addr;
  assign sram_b_addr_rd = addr;

  // Saturated pixel count from the live dimensions; only latched on start.
  always_comb begin
    prod_c     = 32'(img_width) * 32'(img_height);
    total_px_c = (prod_c > 32'(MAX_PIXELS)) ? PX_W'(MAX_PIXELS) : PX_W'(prod_c);
  end

  // Word being captured: valid-pixel count and zeroing of unused tail bytes.
  always_comb begin
    is_last_c = (CMP_W'(addr) == last_addr);
    vpx_c     = (is_last_c && (px_rem != 2'd0)) ? {1'b0, px_rem} : 3'd4;
    red_c     = '0;
    green_c   = '0;
    blue_c    = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < vpx_c) begin
        red_c[8*i +: 8]   = sram_r_rd_data[8*i +: 8];
        green_c[8*i +: 8] = sram_g_rd_data[8*i +: 8];
        blue_c[8*i +: 8]  = sram_b_rd_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      addr                   <= '0;
      last_addr              <= '0;
      px_rem                 <= '0;
      wait_cnt               <= '0;
      rd_en                  <= 1'b0;
      start_request_to_cmpsr <= 1'b0;
      red_burst              <= '0;
      green_burst            <= '0;
      blue_burst             <= '0;
      burst_valid_px         <= '0;
      burst_last             <= 1'b0;
      tx_seq_burst_busy      <= 1'b0;
      tx_seq_burst_dn        <= 1'b0;
    end else begin
      rd_en                  <= 1'b0;
      start_request_to_cmpsr <= 1'b0;
      tx_seq_burst_dn        <= 1'b0;
      if (abort) begin
        state             <= IDLE;
        addr              <= '0;
        red_burst         <= '0;
        green_burst       <= '0;
        blue_burst        <= '0;
        burst_valid_px    <= '0;
        burst_last        <= 1'b0;
        tx_seq_burst_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              addr      <= '0;
              px_rem    <= total_px_c[1:0];
              last_addr <= CMP_W'((total_px_c + PX_W'(3)) >> 2) - CMP_W'(1);
              if (total_px_c == '0) begin
                state           <= DONE;
                tx_seq_burst_dn <= 1'b1;
              end else begin
                state             <= RD_REQ;
                rd_en             <= 1'b1;
                tx_seq_burst_busy <= 1'b1;
              end
            end
          end
          RD_REQ: begin
            if (RD_LATENCY > 1) begin
              state    <= RD_WAIT;
              wait_cnt <= WAIT_W'(RD_LATENCY - 2);
            end else begin
              state <= CAPTURE;
            end
          end
          RD_WAIT: begin
            if (wait_cnt == '0) state <= CAPTURE;
            else                wait_cnt <= wait_cnt - WAIT_W'(1);
          end
          CAPTURE: begin
            red_burst      <= red_c;
            green_burst    <= green_c;
            blue_burst     <= blue_c;
            burst_valid_px <= vpx_c;
            burst_last     <= is_last_c;
            state          <= SEND;
          end
          SEND: begin
            if (!cmpsr_busy) begin
              start_request_to_cmpsr <= 1'b1;
              state                  <= WAIT_BUSY;
            end
          end
          WAIT_BUSY: begin
            if (cmpsr_busy) state <= WAIT_IDLE;
          end
          WAIT_IDLE: begin
            if (!cmpsr_busy) begin
              if (burst_last) begin
                state             <= DONE;
                tx_seq_burst_dn   <= 1'b1;
                tx_seq_burst_busy <= 1'b0;
              end else begin
                addr  <= addr + ADDR_W'(1);
                rd_en <= 1'b1;
                state <= RD_REQ;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_tx_image_burst.sv
// Directed-sequence bench for seq_tx_image_burst with random SRAM contents,
// a simple composer model and a whole-image reference computed per run.
module tb_seq_tx_image_burst;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LAT    = 1;
  localparam int unsigned MAX_PX = 4096;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam int          RECN   = 4096;

  typedef struct packed {
    logic [31:0]       r;
    logic [31:0]       g;
    logic [31:0]       b;
    logic [2:0]        v;
    logic              l;
    logic [ADDR_W-1:0] a;
  } rec_t;

  logic clk, rst, start, abort;
  logic [15:0] img_width, img_height;
  logic sram_r_rd_en, sram_g_rd_en, sram_b_rd_en;
  logic [ADDR_W-1:0] sram_r_addr_rd, sram_g_addr_rd, sram_b_addr_rd;
  logic [31:0] sram_r_rd_data, sram_g_rd_data, sram_b_rd_data;
  logic cmpsr_busy, start_request_to_cmpsr;
  logic [31:0] red_burst, green_burst, blue_burst;
  logic [2:0] burst_valid_px;
  logic burst_last, tx_seq_burst_busy, tx_seq_burst_dn;

  logic [31:0] mem_r [DEPTH];
  logic [31:0] mem_g [DEPTH];
  logic [31:0] mem_b [DEPTH];

  rec_t recs [RECN];
  int   rec_cyc [RECN];
  int   cyc = 0, rd_cnt = 0, req_cnt = 0, dn_cnt = 0, skew_cnt = 0;
  int   checks = 0, errors = 0;
  int   hold = 1, bcnt;
  logic force_busy;
  int   b_req, b_rd, b_dn, b_cyc, run_w, run_h;

  seq_tx_image_burst #(.ADDR_W(ADDR_W), .RD_LATENCY(LAT), .MAX_PIXELS(MAX_PX)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .img_width(img_width), .img_height(img_height),
    .sram_r_rd_en(sram_r_rd_en), .sram_g_rd_en(sram_g_rd_en), .sram_b_rd_en(sram_b_rd_en),
    .sram_r_addr_rd(sram_r_addr_rd), .sram_g_addr_rd(sram_g_addr_rd),
    .sram_b_addr_rd(sram_b_addr_rd),
    .sram_r_rd_data(sram_r_rd_data), .sram_g_rd_data(sram_g_rd_data),
    .sram_b_rd_data(sram_b_rd_data),
    .cmpsr_busy(cmpsr_busy), .start_request_to_cmpsr(start_request_to_cmpsr),
    .red_burst(red_burst), .green_burst(green_burst), .blue_burst(blue_burst),
    .burst_valid_px(burst_valid_px), .burst_last(burst_last),
    .tx_seq_burst_busy(tx_seq_burst_busy), .tx_seq_burst_dn(tx_seq_burst_dn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency SRAMs, each driven by its own strobe and address.
  always @(posedge clk) begin
    if (sram_r_rd_en) sram_r_rd_data <= mem_r[sram_r_addr_rd];
    if (sram_g_rd_en) sram_g_rd_data <= mem_g[sram_g_addr_rd];
    if (sram_b_rd_en) sram_b_rd_data <= mem_b[sram_b_addr_rd];
  end

  // Composer: busy rises the cycle after a request and lasts 'hold' cycles.
  always @(posedge clk or posedge rst) begin
    if (rst)                         bcnt <= 0;
    else if (start_request_to_cmpsr) bcnt <= hold;
    else if (bcnt != 0)              bcnt <= bcnt - 1;
  end
  assign cmpsr_busy = force_busy | (bcnt != 0);

  always @(negedge clk) begin
    cyc++;
    if (sram_r_rd_en) rd_cnt++;
    if ({sram_r_rd_en, sram_r_addr_rd} !== {sram_g_rd_en, sram_g_addr_rd} ||
        {sram_r_rd_en, sram_r_addr_rd} !== {sram_b_rd_en, sram_b_addr_rd}) skew_cnt++;
    if (start_request_to_cmpsr) begin
      recs[req_cnt % RECN].r = red_burst;
      recs[req_cnt % RECN].g = green_burst;
      recs[req_cnt % RECN].b = blue_burst;
      recs[req_cnt % RECN].v = burst_valid_px;
      recs[req_cnt % RECN].l = burst_last;
      recs[req_cnt % RECN].a = sram_r_addr_rd;
      rec_cyc[req_cnt % RECN] = cyc;
      req_cnt++;
    end
    if (tx_seq_burst_dn) dn_cnt++;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int active_outputs(input bit with_addr);
    int n = 0;
    if (sram_r_rd_en !== 1'b0 || sram_g_rd_en !== 1'b0 || sram_b_rd_en !== 1'b0) n++;
    if (start_request_to_cmpsr !== 1'b0) n++;
    if (red_burst !== '0 || green_burst !== '0 || blue_burst !== '0) n++;
    if (burst_valid_px !== '0 || burst_last !== 1'b0) n++;
    if (tx_seq_burst_busy !== 1'b0 || tx_seq_burst_dn !== 1'b0) n++;
    if (with_addr && sram_r_addr_rd !== '0) n++;
    return n;
  endfunction

  task automatic start_run(input int w, input int h);
    tick;
    run_w = w; run_h = h;
    img_width = 16'(w); img_height = 16'(h);
    b_req = req_cnt; b_rd = rd_cnt; b_dn = dn_cnt;
    start = 1'b1; b_cyc = cyc;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_reqs(input int n, input int budget);
    int t = 0;
    while (req_cnt - b_req < n && t < budget) begin tick; t++; end
    chk("req_reached", 64'(req_cnt - b_req), 64'(n));
  endtask

  // Expected payload stream recomputed from the image rules for the last run.
  task automatic check_run(input bit chk_lat);
    int total, words, bad, valid;
    rec_t e;
    logic [31:0] m;
    total = run_w * run_h;
    if (total > int'(MAX_PX)) total = int'(MAX_PX);
    words = (total + 3) / 4;
    chk("req_count", 64'(req_cnt - b_req), 64'(words));
    chk("rd_en_count", 64'(rd_cnt - b_rd), 64'(words));
    chk("dn_count", 64'(dn_cnt - b_dn), 64'd1);
    bad = 0;
    for (int k = 0; k < words; k++) begin
      valid = (total - 4 * k < 4) ? total - 4 * k : 4;
      m = '0;
      for (int b = 0; b < valid; b++) m[8*b +: 8] = 8'hff;
      e.r = mem_r[k] & m;
      e.g = mem_g[k] & m;
      e.b = mem_b[k] & m;
      e.v = 3'(valid);
      e.l = (k == words - 1);
      e.a = ADDR_W'(k);
      if (recs[(b_req + k) % RECN] !== e) bad++;
    end
    chk("bad_words", 64'(bad), 64'd0);
    if (chk_lat && words > 0)
      chk("first_req_latency", 64'(rec_cyc[b_req % RECN] - b_cyc), 64'd4);
  endtask

  task automatic finish_run(input int budget, input bit chk_lat);
    int t = 0;
    while (dn_cnt == b_dn && t < budget) begin tick; t++; end
    chk("done_seen", 64'(dn_cnt != b_dn), 64'd1);
    tick;
    chk("busy_after_done", 64'(tx_seq_burst_busy), 64'd0);
    check_run(chk_lat);
  endtask

  initial begin
    int s_rd, s_dn;
    rst = 1'b1; start = 1'b0; abort = 1'b0; force_busy = 1'b0;
    img_width = '0; img_height = '0;
    for (int k = 0; k < DEPTH; k++) begin
      mem_r[k] = $urandom; mem_g[k] = $urandom; mem_b[k] = $urandom;
    end
    mem_r[0] = 32'h04030201; mem_g[0] = 32'h14131211; mem_b[0] = 32'h24232221;
    repeat (3) tick;
    chk("reset_outputs", 64'(active_outputs(1'b1)), 64'd0);
    rst = 1'b0;
    tick;
    chk("idle_outputs", 64'(active_outputs(1'b1)), 64'd0);

    // 2x2: single full word.
    start_run(2, 2);
    chk("busy_after_start", 64'(tx_seq_burst_busy), 64'd1);
    finish_run(100, 1'b1);
    chk("w0_red", 64'(recs[b_req % RECN].r), 64'h04030201);
    chk("w0_green", 64'(recs[b_req % RECN].g), 64'h14131211);
    chk("w0_blue", 64'(recs[b_req % RECN].b), 64'h24232221);
    chk("w0_valid_last", 64'({recs[b_req % RECN].v, recs[b_req % RECN].l}), 64'h9);

    // 3x3 with a start (and new dimensions) arriving mid-run.
    start_run(3, 3);
    wait_reqs(1, 100);
    tick;
    img_width = 16'd7; img_height = 16'd7; start = 1'b1;
    tick;
    start = 1'b0;
    finish_run(200, 1'b1);
    chk("w2_valid", 64'(recs[(b_req + 2) % RECN].v), 64'd1);
    chk("w2_upper_zero", 64'(recs[(b_req + 2) % RECN].r[31:8]), 64'd0);

    // Composer holds busy for 20 cycles after the first request.
    hold = 20;
    start_run(2, 4);
    wait_reqs(1, 100);
    repeat (12) tick;
    chk("stall_req", 64'(req_cnt - b_req), 64'd1);
    chk("stall_rd", 64'(rd_cnt - b_rd), 64'd1);
    chk("stall_busy", 64'(tx_seq_burst_busy), 64'd1);
    finish_run(200, 1'b1);
    hold = 1;

    // Composer already busy: request must wait.
    force_busy = 1'b1;
    start_run(1, 1);
    repeat (10) tick;
    chk("held_req", 64'(req_cnt - b_req), 64'd0);
    chk("held_rd", 64'(rd_cnt - b_rd), 64'd1);
    force_busy = 1'b0;
    finish_run(100, 1'b0);

    // Zero-sized images.
    start_run(0, 5);
    chk("zero_dn", 64'(tx_seq_burst_dn), 64'd1);
    chk("zero_busy", 64'(tx_seq_burst_busy), 64'd0);
    finish_run(20, 1'b0);
    start_run(9, 0);
    finish_run(20, 1'b0);

    // Abort at word 5 of 16.
    start_run(8, 8);
    wait_reqs(5, 300);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_outputs", 64'(active_outputs(1'b0)), 64'd0);
    repeat (10) tick;
    chk("abort_no_dn", 64'(dn_cnt - b_dn), 64'd0);
    chk("abort_req_frozen", 64'(req_cnt - b_req), 64'd5);

    // Start and abort together in IDLE: abort wins.
    s_rd = rd_cnt;
    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    repeat (5) tick;
    chk("start_abort_rd", 64'(rd_cnt - s_rd), 64'd0);
    chk("start_abort_busy", 64'(tx_seq_burst_busy), 64'd0);

    start_run(2, 3);
    finish_run(200, 1'b1);

    // Reset mid-burst.
    start_run(8, 8);
    wait_reqs(3, 300);
    s_dn = dn_cnt;
    rst = 1'b1;
    #1;
    chk("rst_outputs", 64'(active_outputs(1'b1)), 64'd0);
    tick;
    tick;
    rst = 1'b0;
    repeat (5) tick;
    chk("rst_no_dn", 64'(dn_cnt - s_dn), 64'd0);
    chk("rst_idle", 64'(active_outputs(1'b1)), 64'd0);
    start_run(2, 2);
    finish_run(100, 1'b1);

    // Full frame and saturated frame.
    start_run(64, 64);
    finish_run(20000, 1'b1);
    chk("full_last_addr", 64'(recs[(req_cnt - 1) % RECN].a), 64'(DEPTH - 1));
    chk("full_last_flag", 64'(recs[(req_cnt - 1) % RECN].l), 64'd1);
    start_run(300, 300);
    finish_run(20000, 1'b1);
    chk("sat_last_addr", 64'(recs[(req_cnt - 1) % RECN].a), 64'(DEPTH - 1));

    chk("rd_strobe_skew", 64'(skew_cnt), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
